// File: rtl/nss_pkg.sv
// Shared types and helpers for the nibble-serial subtractor.
// Holds the slice width, the controller state encoding and the borrow generate/propagate helper.
package nss_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [NIBBLE_W-1:0] g;
        logic [NIBBLE_W-1:0] p;
    } gp_t;

    // Bit i generates a borrow when a=0,b=1; it passes an incoming borrow through when a==b.
    function automatic gp_t borrow_gp(input logic [NIBBLE_W-1:0] a,
                                      input logic [NIBBLE_W-1:0] b);
        gp_t r;
        r.g = ~a & b;
        r.p = ~(a ^ b);
        return r;
    endfunction

endpackage

// File: rtl/nibble_sub.sv
// 4-bit combinational borrow-lookahead subtractor: {bout, d} = a - b - bin.
// Every borrow is a flat sum of products over generate/propagate terms.
module nibble_sub
    import nss_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);

    gp_t        gp;
    logic [4:0] br;

    always_comb begin
        gp    = borrow_gp(a, b);
        br[0] = bin;
        br[1] = gp.g[0] | (gp.p[0] & bin);
        br[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & bin);
        br[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
              | (gp.p[2] & gp.p[1] & gp.p[0] & bin);
        br[4] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
              | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
              | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & bin);
        d     = a ^ b ^ br[3:0];
        bout  = br[4];
    end

    // In 5-bit two's complement, a - b - bin == d - 16*bout is the same as {bout,d}.
    always_comb begin
        assert (({1'b0, a} - {1'b0, b} - {4'b0000, bin}) == {bout, d});
    end

endmodule

// File: rtl/nibble_serial_sub.sv
// Nibble-serial WIDTH-bit subtractor: one 4-bit slice per cycle with chained borrow,
// behind valid/ready operand and result handshakes. All outputs are registered.
module nibble_serial_sub
    import nss_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int unsigned NIB    = WIDTH / NIBBLE_W;
    localparam int unsigned KW     = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    diff_q, diff_d;
    logic [KW-1:0]       k_q, k_d;
    logic                borrow_q, borrow_d;
    logic                bout_q, bout_d;
    logic                zero_q, zero_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_d;
    logic                slice_bout;

    always_comb begin
        slice_a = a_q[k_q*NIBBLE_W +: NIBBLE_W];
        slice_b = b_q[k_q*NIBBLE_W +: NIBBLE_W];
    end

    nibble_sub u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_ready_q && in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[k_q*NIBBLE_W +: NIBBLE_W] = slice_d;
                borrow_d = slice_bout;
                if (k_q == K_LAST) begin
                    bout_d  = slice_bout;
                    zero_d  = (diff_d == '0);
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered from the next state so they stay low during reset.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            k_q         <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            k_q         <= k_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: directed vector table, handshake corner
// sequences, and random operands on 4-, 16- and 32-bit instances.
module tb_nibble_serial_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv4, ir4, ov4, or4, bi4, bo4, z4;
    logic [3:0]  a4, b4, d4;
    logic        iv16, ir16, ov16, or16, bi16, bo16, z16;
    logic [15:0] a16, b16, d16;
    logic        iv32, ir32, ov32, or32, bi32, bo32, z32;
    logic [31:0] a32, b32, d32;

    nibble_serial_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .bin(bi4),
        .out_valid(ov4), .out_ready(or4), .diff(d4), .bout(bo4), .zero(z4)
    );
    nibble_serial_sub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bi16),
        .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16), .zero(z16)
    );
    nibble_serial_sub #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .bin(bi32),
        .out_valid(ov32), .out_ready(or32), .diff(d32), .bout(bo32), .zero(z32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } vec_t;

    vec_t vecs[10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One 16-bit operation with out_ready held high; checks latency, result and return to IDLE.
    task automatic do16(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input logic [15:0] ed, input logic eb, input logic ez, input string tag);
        int lat;
        check({tag, ".in_ready"}, 64'(ir16), 64'd1);
        a16 = a; b16 = b; bi16 = bi; or16 = 1'b1; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd4);
        check({tag, ".diff"}, 64'(d16), 64'(ed));
        check({tag, ".bout"}, 64'(bo16), 64'(eb));
        check({tag, ".zero"}, 64'(z16), 64'(ez));
        tick();
        check({tag, ".taken_valid"}, 64'(ov16), 64'd0);
        check({tag, ".taken_ready"}, 64'(ir16), 64'd1);
    endtask

    task automatic rcheck(input string nm, input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic bi, input logic [63:0] d, input logic bo, input logic z,
                          input int lat, input int nib);
        longint     lhs, rhs;
        logic [63:0] mask, expd;
        lhs  = longint'(a) - longint'(b) - longint'({63'd0, bi});
        rhs  = longint'(d) - (longint'({63'd0, bo}) <<< w);
        mask = (64'd1 << w) - 64'd1;
        expd = (a - b - {63'd0, bi}) & mask;
        check({nm, ".latency"}, 64'(lat), 64'(nib));
        check({nm, ".invariant"}, 64'(rhs), 64'(lhs));
        check({nm, ".zero"}, 64'(z), 64'(expd == 64'd0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        iv4 = 0; or4 = 1; bi4 = 0; a4 = '0; b4 = '0;
        iv16 = 0; or16 = 1; bi16 = 0; a16 = '0; b16 = '0;
        iv32 = 0; or32 = 1; bi32 = 0; a32 = '0; b32 = '0;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[8] = '{16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};

        #2;
        check("reset.in_ready", 64'(ir16), 64'd0);
        check("reset.out_valid", 64'(ov16), 64'd0);
        check("reset.diff", 64'(d16), 64'd0);
        check("reset.bout", 64'(bo16), 64'd0);
        check("reset.zero", 64'(z16), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("release.in_ready", 64'(ir16), 64'd1);

        for (int i = 0; i < 10; i++) begin
            do16(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].zero,
                 $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while new operands are offered and ignored.
        begin
            int lat;
            a16 = 16'h0000; b16 = 16'h0001; bi16 = 1'b0; or16 = 1'b0; iv16 = 1'b1;
            tick();
            iv16 = 1'b0;
            lat = 0;
            while (!ov16 && lat < 20) begin
                tick();
                lat++;
            end
            check("bp.latency", 64'(lat), 64'd4);
            for (int i = 0; i < 6; i++) begin
                iv16 = (i % 2 == 0);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                bi16 = 1'($urandom_range(0, 1));
                tick();
                check("bp.out_valid", 64'(ov16), 64'd1);
                check("bp.diff", 64'(d16), 64'hFFFF);
                check("bp.bout", 64'(bo16), 64'd1);
                check("bp.zero", 64'(z16), 64'd0);
                check("bp.in_ready", 64'(ir16), 64'd0);
            end
            iv16 = 1'b0;
            or16 = 1'b1;
            tick();
            check("bp.release_valid", 64'(ov16), 64'd0);
            check("bp.release_ready", 64'(ir16), 64'd1);
            tick();
            tick();
            check("bp.no_capture_valid", 64'(ov16), 64'd0);
            check("bp.held_diff", 64'(d16), 64'hFFFF);
        end

        // Reset in the second RUN cycle aborts the operation.
        begin
            logic seen_valid;
            a16 = 16'h1234; b16 = 16'h0034; bi16 = 1'b0; or16 = 1'b1; iv16 = 1'b1;
            tick();
            iv16 = 1'b0;
            tick();
            rst_n = 1'b0;
            #1;
            check("abort.out_valid", 64'(ov16), 64'd0);
            check("abort.diff", 64'(d16), 64'd0);
            check("abort.in_ready", 64'(ir16), 64'd0);
            check("abort.bout", 64'(bo16), 64'd0);
            tick();
            tick();
            check("abort.hold_ready", 64'(ir16), 64'd0);
            rst_n = 1'b1;
            tick();
            check("abort.release_ready", 64'(ir16), 64'd1);
            seen_valid = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (ov16) seen_valid = 1'b1;
            end
            check("abort.no_result", 64'(seen_valid), 64'd0);
            do16(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, "post_reset");
        end

        // Random operands on all three widths, started together.
        for (int it = 0; it < 1000; it++) begin
            logic [31:0] ra, rb;
            logic        rbi;
            int          l4, l16, l32;
            logic [3:0]  r4d;
            logic [15:0] r16d;
            logic [31:0] r32d;
            logic        r4b, r4z, r16b, r16z, r32b, r32z;
            ra = $urandom;
            rb = $urandom;
            rbi = 1'($urandom_range(0, 1));
            a4 = ra[3:0];   b4 = rb[3:0];   bi4 = rbi;
            a16 = ra[15:0]; b16 = rb[15:0]; bi16 = rbi;
            a32 = ra;       b32 = rb;       bi32 = rbi;
            or4 = 1'b1; or16 = 1'b1; or32 = 1'b1;
            iv4 = 1'b1; iv16 = 1'b1; iv32 = 1'b1;
            tick();
            iv4 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
            l4 = -1; l16 = -1; l32 = -1;
            r4d = '0; r16d = '0; r32d = '0;
            r4b = 0; r4z = 0; r16b = 0; r16z = 0; r32b = 0; r32z = 0;
            for (int c = 1; c <= 12; c++) begin
                tick();
                if (ov4 && l4 < 0) begin l4 = c; r4d = d4; r4b = bo4; r4z = z4; end
                if (ov16 && l16 < 0) begin l16 = c; r16d = d16; r16b = bo16; r16z = z16; end
                if (ov32 && l32 < 0) begin l32 = c; r32d = d32; r32b = bo32; r32z = z32; end
            end
            rcheck($sformatf("rnd4_%0d", it), 4, 64'(ra[3:0]), 64'(rb[3:0]), rbi,
                   64'(r4d), r4b, r4z, l4, 1);
            rcheck($sformatf("rnd16_%0d", it), 16, 64'(ra[15:0]), 64'(rb[15:0]), rbi,
                   64'(r16d), r16b, r16z, l16, 4);
            rcheck($sformatf("rnd32_%0d", it), 32, 64'(ra), 64'(rb), rbi,
                   64'(r32d), r32b, r32z, l32, 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
